// File: rtl/alu_operand_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | alu_operand_sequencer_if : switch/button/ALU bus of the operand sequencer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface alu_operand_sequencer_if #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
) ();

  logic [SIZEDATA-1:0] SWITCHES;
  logic                BTN_NEXT;
  logic                BTN_CLEAR;
  logic [SIZEDATA-1:0] ALU_RESULT;
  // Operands are two's complement; signedness is interpreted by the ALU.
  logic [SIZEDATA-1:0] DATOA;
  logic [SIZEDATA-1:0] DATOB;
  logic [SIZEOP-1:0]   OPCODE;
  logic [SIZEDATA-1:0] LEDS;
  logic [2:0]          STATE;
  logic                DONE;

  modport master (
    input  SWITCHES, BTN_NEXT, BTN_CLEAR, ALU_RESULT,
    output DATOA, DATOB, OPCODE, LEDS, STATE, DONE
  );

  modport slave (
    output SWITCHES, BTN_NEXT, BTN_CLEAR, ALU_RESULT,
    input  DATOA, DATOB, OPCODE, LEDS, STATE, DONE
  );

endinterface
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | alu_operand_sequencer : single-button A/B/opcode loader with held result   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_operand_sequencer #(
  parameter int SIZEDATA        = 8,
  parameter int SIZEOP          = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  wire logic               CLK,
  input  wire logic               RESET,
  alu_operand_sequencer_if.master bus
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam int                 c_nbtn     = 2;
  localparam int                 c_btn_next = 0;
  localparam int                 c_btn_clr  = 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic [c_nbtn-1:0] w_btn_raw;
  logic [c_nbtn-1:0] w_btn_pulse;
  logic              w_p_next;
  logic              w_p_clear;

  assign w_btn_raw[c_btn_next] = bus.BTN_NEXT;
  assign w_btn_raw[c_btn_clr]  = bus.BTN_CLEAR;

  // Per button: 2-FF synchronizer, stability-counter debounce, rising-edge pulse.
  for (genvar gi = 0; gi < c_nbtn; gi++) begin : g_btn
    logic               r_meta;
    logic               r_sync;
    logic               r_db;
    logic               r_db_q;
    logic               r_pulse;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_db    <= 1'b0;
        r_db_q  <= 1'b0;
        r_pulse <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_meta  <= w_btn_raw[gi];
        r_sync  <= r_meta;
        r_db_q  <= r_db;
        r_pulse <= r_db & ~r_db_q;
        if (r_sync == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_db  <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end

    assign w_btn_pulse[gi] = r_pulse;
  end

  assign w_p_next  = w_btn_pulse[c_btn_next];
  assign w_p_clear = w_btn_pulse[c_btn_clr];

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load_a;
  logic   w_load_b;
  logic   w_load_op;
  logic   w_capture;
  logic   w_clear;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear overrides every state, so a coincident NEXT is simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_load_op   = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    if (w_p_clear) begin
      w_clear     = 1'b1;
      w_state_nxt = S_A;
    end else begin
      case (r_state)
        S_A: begin
          if (w_p_next) begin
            w_load_a    = 1'b1;
            w_state_nxt = S_B;
          end
        end
        S_B: begin
          if (w_p_next) begin
            w_load_b    = 1'b1;
            w_state_nxt = S_OP;
          end
        end
        S_OP: begin
          if (w_p_next) begin
            w_load_op   = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (w_p_next) begin
            w_state_nxt = S_A;
          end
        end
        default: begin
          w_state_nxt = S_A;
        end
      endcase
    end
  end

  logic [SIZEDATA-1:0] r_dato_a;
  logic [SIZEDATA-1:0] r_dato_b;
  logic [SIZEOP-1:0]   r_opcode;
  logic [SIZEDATA-1:0] r_leds;
  logic                r_done;

  // LEDS only samples the ALU in S_EXEC, after OPCODE has settled for a cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_dato_a <= '0;
      r_dato_b <= '0;
      r_opcode <= '0;
      r_leds   <= '0;
      r_done   <= 1'b0;
    end else if (w_clear) begin
      r_dato_a <= '0;
      r_dato_b <= '0;
      r_opcode <= '0;
      r_leds   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_load_a) begin
        r_dato_a <= bus.SWITCHES;
      end
      if (w_load_b) begin
        r_dato_b <= bus.SWITCHES;
      end
      if (w_load_op) begin
        r_opcode <= bus.SWITCHES[SIZEOP-1:0];
      end
      if (w_capture) begin
        r_leds <= bus.ALU_RESULT;
      end
    end
  end

  assign bus.DATOA  = r_dato_a;
  assign bus.DATOB  = r_dato_b;
  assign bus.OPCODE = r_opcode;
  assign bus.LEDS   = r_leds;
  assign bus.STATE  = r_state;
  assign bus.DONE   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for alu_operand_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_operand_sequencer;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   done_count = 0;
  logic [7:0] exp_q[$];

  alu_operand_sequencer_if #(.SIZEDATA(8), .SIZEOP(6)) bus ();

  alu_operand_sequencer #(
    .SIZEDATA       (8),
    .SIZEOP         (6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.ALU_RESULT = alu_f(bus.DATOA, bus.DATOB, bus.OPCODE);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] sw, input int hold);
    @(negedge clk);
    bus.SWITCHES = sw;
    bus.BTN_NEXT = 1'b1;
    repeat (hold) @(negedge clk);
    bus.BTN_NEXT = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"},  32'(bus.STATE),  0);
    check({tag, "_datoa"},  32'(bus.DATOA),  0);
    check({tag, "_datob"},  32'(bus.DATOB),  0);
    check({tag, "_opcode"}, 32'(bus.OPCODE), 0);
    check({tag, "_leds"},   32'(bus.LEDS),   0);
    check({tag, "_done"},   32'(bus.DONE),   0);
  endtask

  // Scoreboard consumer: every DONE must match a queued expected result.
  always @(negedge clk) begin
    if (rst_n && bus.DONE) begin
      done_count++;
      check("done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("done_leds", 32'(bus.LEDS), 32'(exp_q.pop_front()));
        check("done_state", 32'(bus.STATE), 4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.SWITCHES  = 8'h00;
    bus.BTN_NEXT  = 1'b0;
    bus.BTN_CLEAR = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in S_OP
    step(8'h12, 12);
    step(8'h34, 12);
    check("t1_datoa", 32'(bus.DATOA), 32'h12);
    check("t1_state_op", 32'(bus.STATE), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t1_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full ADD flow
    step(8'h05, 12);
    check("t2_datoa", 32'(bus.DATOA), 32'h05);
    check("t2_state_b", 32'(bus.STATE), 1);
    step(8'h03, 12);
    check("t2_datob", 32'(bus.DATOB), 32'h03);
    check("t2_state_op", 32'(bus.STATE), 2);
    exp_q.push_back(alu_f(8'h05, 8'h03, 6'h20));
    step(8'h20, 12);
    check("t2_opcode", 32'(bus.OPCODE), 32'h20);
    check("t2_leds", 32'(bus.LEDS), 32'h08);
    check("t2_state_show", 32'(bus.STATE), 4);

    // Short glitch ignored, long hold gives one step
    @(negedge clk);
    bus.BTN_NEXT = 1'b1;
    repeat (3) @(negedge clk);
    bus.BTN_NEXT = 1'b0;
    repeat (15) @(negedge clk);
    check("t3_glitch_state", 32'(bus.STATE), 4);
    step(8'h00, 20);
    check("t3_hold_state", 32'(bus.STATE), 0);
    check("t3_datoa_kept", 32'(bus.DATOA), 32'h05);
    check("t3_leds_kept", 32'(bus.LEDS), 32'h08);

    // SUB flow, LEDS held until execute, upper switch bits dropped from opcode
    step(8'hFF, 12);
    check("t5_datoa", 32'(bus.DATOA), 32'hFF);
    check("t5_leds_hold_a", 32'(bus.LEDS), 32'h08);
    step(8'h01, 12);
    check("t5_datob", 32'(bus.DATOB), 32'h01);
    check("t5_leds_hold_b", 32'(bus.LEDS), 32'h08);
    exp_q.push_back(alu_f(8'hFF, 8'h01, 6'h22));
    step(8'hE2, 12);
    check("t5_opcode", 32'(bus.OPCODE), 32'h22);
    check("t5_leds", 32'(bus.LEDS), 32'hFE);
    check("t5_state_show", 32'(bus.STATE), 4);
    step(8'h00, 12);
    check("t5_back_to_a", 32'(bus.STATE), 0);

    // NEXT and CLEAR together in S_B
    step(8'h11, 12);
    check("t4_state_b", 32'(bus.STATE), 1);
    @(negedge clk);
    bus.SWITCHES  = 8'h77;
    bus.BTN_NEXT  = 1'b1;
    bus.BTN_CLEAR = 1'b1;
    repeat (12) @(negedge clk);
    bus.BTN_NEXT  = 1'b0;
    bus.BTN_CLEAR = 1'b0;
    repeat (12) @(negedge clk);
    check_all_zero("t4_clear");

    // CLEAR pulse lands one cycle after NEXT pulse, i.e. in S_EXEC
    step(8'h09, 12);
    step(8'h04, 12);
    check("t6_state_op", 32'(bus.STATE), 2);
    @(negedge clk);
    bus.SWITCHES = 8'h20;
    bus.BTN_NEXT = 1'b1;
    @(negedge clk);
    bus.BTN_CLEAR = 1'b1;
    repeat (12) @(negedge clk);
    bus.BTN_NEXT  = 1'b0;
    bus.BTN_CLEAR = 1'b0;
    repeat (12) @(negedge clk);
    check_all_zero("t6_exec_clear");

    check("pending_results", 32'(exp_q.size()), 0);
    check("done_count", 32'(done_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
